// File: rtl/score_keeper.sv
// score_keeper: match-level scoring and flow control between game_controller
// and vga_controller. Counts goal edges into per-team BCD digits, freezes play
// for a fixed pause after each goal, and holds the final result until restart.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       team1_score,
  input  logic       team2_score,
  input  logic       restart_button,
  output logic [3:0] team1_points,
  output logic [3:0] team2_points,
  output logic       freeze,
  output logic       ball_reset,
  output logic       game_over,
  output logic [1:0] winner
);

  // Match states
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [3:0]       WIN_BCD    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  // Index 0 is team1, index 1 is team2 throughout.
  logic [1:0] score_lvl;
  logic [1:0] prev_q;
  logic [1:0] goal;
  logic [1:0] hit_win;
  logic [3:0] points_q   [2];
  logic [3:0] points_d   [2];
  logic [3:0] points_inc [2];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       winner_q, winner_d;
  logic             freeze_q, freeze_d;
  logic             ball_reset_q, ball_reset_d;
  logic             game_over_q, game_over_d;

  // Restart button synchronizer and edge detector
  logic sync1_q, sync2_q, sync_prev_q;
  logic restart;

  assign score_lvl = {team2_score, team1_score};
  assign restart   = sync2_q & ~sync_prev_q;

  // Per-team goal edge, saturating increment and win detection
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_team
      assign goal[gi]       = score_lvl[gi] & ~prev_q[gi];
      assign points_inc[gi] = (goal[gi] && (points_q[gi] != WIN_BCD))
                              ? points_q[gi] + 4'd1 : points_q[gi];
      assign hit_win[gi]    = goal[gi] && (points_inc[gi] == WIN_BCD);
    end
  endgenerate

  // Next-state logic for the match FSM, scores, winner and pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    points_d[0]  = points_q[0];
    points_d[1]  = points_q[1];
    winner_d     = winner_q;
    ball_reset_d = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (|goal) begin
          points_d[0]  = points_inc[0];
          points_d[1]  = points_inc[1];
          ball_reset_d = 1'b1;
          if (|hit_win) begin
            // bit0 = team1 won, bit1 = team2 won; both set means a draw
            state_d  = ST_OVER;
            winner_d = hit_win;
          end else begin
            state_d = ST_PAUSE;
            cnt_d   = PAUSE_LOAD;
          end
        end
      end
      ST_PAUSE: begin
        // Goals are ignored here; the edge registers still track the inputs
        // so a level still high at resume does not count.
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OVER: begin
        if (restart) begin
          points_d[0]  = 4'd0;
          points_d[1]  = 4'd0;
          winner_d     = 2'b00;
          ball_reset_d = 1'b1;
          state_d      = ST_PAUSE;
          cnt_d        = PAUSE_LOAD;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase

    // Status outputs follow the state being entered so they stay registered.
    freeze_d    = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // State, edge-detect, synchronizer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PLAY;
      cnt_q        <= '0;
      prev_q       <= 2'b00;
      points_q[0]  <= 4'd0;
      points_q[1]  <= 4'd0;
      winner_q     <= 2'b00;
      freeze_q     <= 1'b0;
      ball_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= score_lvl;
      points_q[0]  <= points_d[0];
      points_q[1]  <= points_d[1];
      winner_q     <= winner_d;
      freeze_q     <= freeze_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
      sync1_q      <= restart_button;
      sync2_q      <= sync1_q;
      sync_prev_q  <= sync2_q;
    end
  end

  assign team1_points = points_q[0];
  assign team2_points = points_q[1];
  assign winner       = winner_q;
  assign freeze       = freeze_q;
  assign ball_reset   = ball_reset_q;
  assign game_over    = game_over_q;

endmodule
